// File: rtl/branch_resolve_btb.sv
// ID-stage conditional-branch resolution with a direct-mapped BTB predictor.
// Mispredicts redirect the PC and flush IF/ID in the same cycle; branch and mispredict counts saturate.
module branch_resolve_btb #(
  parameter int IDX_W = 4,
  parameter int XLEN  = 32
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_TARGET,
  input  logic            ID_VALID,
  input  logic            ID_IS_BRANCH,
  input  logic [2:0]      ID_FUNCT3,
  input  logic [XLEN-1:0] ID_PC,
  input  logic [XLEN-1:0] ID_IMM,
  input  logic            ID_PRED_TAKEN,
  input  logic [XLEN-1:0] ID_PRED_TARGET,
  input  logic            STALL_ID,
  input  logic            BrEq,
  input  logic            BrLt,
  output logic            is_sign,
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC,
  output logic            FLUSH_IF_ID,
  output logic [31:0]     BR_CNT,
  output logic [31:0]     MISP_CNT
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [31:0]        br_cnt_q, br_cnt_d;
  logic [31:0]        misp_cnt_q, misp_cnt_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  logic            legal, resolve, taken, mispredict, write_en;
  logic [XLEN-1:0] tgt, seq;
  logic [1:0]      ctr_d;
  logic [XLEN-1:0] target_d;

  logic unused_if_pc_lsbs;
  assign unused_if_pc_lsbs = ^IF_PC[1:0];

  // Fetch-side lookup reads the array as it stood before any same-cycle update.
  assign lk_idx      = IF_PC[IDX_W+1:2];
  assign lk_tag      = IF_PC[XLEN-1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign PRED_TAKEN  = RSTn && lk_hit && ctr_q[lk_idx][1];
  assign PRED_TARGET = (RSTn && lk_hit) ? target_q[lk_idx] : '0;

  assign up_idx = ID_PC[IDX_W+1:2];
  assign up_tag = ID_PC[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign is_sign = (ID_FUNCT3 == 3'b100) || (ID_FUNCT3 == 3'b101);
  assign legal   = (ID_FUNCT3 != 3'b010) && (ID_FUNCT3 != 3'b011);
  assign resolve = RSTn && ID_VALID && ID_IS_BRANCH && legal && !STALL_ID;
  assign tgt     = ID_PC + ID_IMM;
  assign seq     = ID_PC + PC_STEP;

  always_comb begin
    taken = 1'b0;
    case (ID_FUNCT3)
      3'b000:         taken = BrEq;
      3'b001:         taken = !BrEq;
      3'b100, 3'b110: taken = BrLt;
      3'b101, 3'b111: taken = !BrLt;
      default:        taken = 1'b0;
    endcase
  end

  assign mispredict  = resolve && ((taken != ID_PRED_TAKEN) ||
                                   (taken && ID_PRED_TAKEN && (ID_PRED_TARGET != tgt)));
  assign REDIRECT    = mispredict;
  assign FLUSH_IF_ID = mispredict;
  assign REDIRECT_PC = mispredict ? (taken ? tgt : seq) : '0;

  // A not-taken branch that misses the BTB leaves it untouched.
  always_comb begin
    write_en = resolve && (up_hit || taken);
    ctr_d    = 2'b10;
    target_d = tgt;
    if (up_hit) begin
      if (taken) begin
        ctr_d    = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
        target_d = tgt;
      end else begin
        ctr_d    = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
        target_d = target_q[up_idx];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (write_en) begin
      valid_q[up_idx]  <= 1'b1;
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= target_d;
      ctr_q[up_idx]    <= ctr_d;
    end
  end

  assign br_cnt_d   = (resolve && (br_cnt_q != '1)) ? br_cnt_q + 32'd1 : br_cnt_q;
  assign misp_cnt_d = (mispredict && (misp_cnt_q != '1)) ? misp_cnt_q + 32'd1 : misp_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      br_cnt_q   <= '0;
      misp_cnt_q <= '0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      misp_cnt_q <= misp_cnt_d;
    end
  end

  assign BR_CNT   = br_cnt_q;
  assign MISP_CNT = misp_cnt_q;

endmodule

// File: tb/tb_branch_resolve_btb.sv
// Directed bench for branch_resolve_btb: expectations are queued as each step is driven,
// then popped and compared once the DUT outputs for that step are settled.
module tb_branch_resolve_btb;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] ifPc;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        idValid, idIsBranch;
  logic [2:0]  idFunct3;
  logic [31:0] idPc, idImm;
  logic        idPredTaken;
  logic [31:0] idPredTarget;
  logic        stallId, brEq, brLt;
  logic        isSign, redirect, flushIfId;
  logic [31:0] redirectPc, brCnt, mispCnt;

  localparam int SEL_PT   = 0;
  localparam int SEL_PTGT = 1;
  localparam int SEL_RED  = 2;
  localparam int SEL_RPC  = 3;
  localparam int SEL_FL   = 4;
  localparam int SEL_BR   = 5;
  localparam int SEL_MISP = 6;
  localparam int SEL_SIGN = 7;

  typedef struct {
    int          sel;
    string       name;
    logic [31:0] exp;
  } expT;

  expT sb[$];
  int  checks   = 0;
  int  failures = 0;
  int  expBr    = 0;
  int  expMisp  = 0;

  branch_resolve_btb #(.IDX_W(4), .XLEN(32)) dut (
    .CLK           (clk),
    .RSTn          (rstN),
    .IF_PC         (ifPc),
    .PRED_TAKEN    (predTaken),
    .PRED_TARGET   (predTarget),
    .ID_VALID      (idValid),
    .ID_IS_BRANCH  (idIsBranch),
    .ID_FUNCT3     (idFunct3),
    .ID_PC         (idPc),
    .ID_IMM        (idImm),
    .ID_PRED_TAKEN (idPredTaken),
    .ID_PRED_TARGET(idPredTarget),
    .STALL_ID      (stallId),
    .BrEq          (brEq),
    .BrLt          (brLt),
    .is_sign       (isSign),
    .REDIRECT      (redirect),
    .REDIRECT_PC   (redirectPc),
    .FLUSH_IF_ID   (flushIfId),
    .BR_CNT        (brCnt),
    .MISP_CNT      (mispCnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_PT:   return {31'd0, predTaken};
      SEL_PTGT: return predTarget;
      SEL_RED:  return {31'd0, redirect};
      SEL_RPC:  return redirectPc;
      SEL_FL:   return {31'd0, flushIfId};
      SEL_BR:   return brCnt;
      SEL_MISP: return mispCnt;
      default:  return {31'd0, isSign};
    endcase
  endfunction

  task automatic pushExp(input int sel, input string name, input logic [31:0] exp);
    expT e;
    e.sel  = sel;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic pushCounts();
    pushExp(SEL_BR, "br_cnt", expBr);
    pushExp(SEL_MISP, "misp_cnt", expMisp);
  endtask

  task automatic applyStimulus(input logic [31:0] pcIf, input logic valid, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                               input logic [31:0] ptgt, input logic stall, input logic eq,
                               input logic lt);
    ifPc         = pcIf;
    idValid      = valid;
    idIsBranch   = valid;
    idFunct3     = f3;
    idPc         = pc;
    idImm        = imm;
    idPredTaken  = pt;
    idPredTarget = ptgt;
    stallId      = stall;
    brEq         = eq;
    brLt         = lt;
    #1;
  endtask

  task automatic idle(input logic [31:0] pcIf);
    applyStimulus(pcIf, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput();
    expT e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.name, obs, e.exp);
      end
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    idle(32'h100);
    #11;
    rstN = 1'b1;
    #1;
    pushExp(SEL_PT, "reset_pred_taken", 0);
    pushExp(SEL_PTGT, "reset_pred_target", 0);
    pushExp(SEL_RED, "reset_redirect", 0);
    pushCounts();
    checkOutput();
    nextCycle();

    // BEQ taken, predicted not-taken: miss allocates entry with weakly-taken counter
    applyStimulus(32'h100, 1, 3'b000, 32'h100, 32'h20, 0, 32'h0, 0, 1, 0);
    pushExp(SEL_RED, "beq_redirect", 1);
    pushExp(SEL_FL, "beq_flush", 1);
    pushExp(SEL_RPC, "beq_redirect_pc", 32'h120);
    pushExp(SEL_SIGN, "beq_is_sign", 0);
    pushExp(SEL_PT, "beq_same_cycle_lookup", 0);
    checkOutput();
    expBr++; expMisp++;
    nextCycle();
    idle(32'h100);
    pushExp(SEL_PT, "alloc_pred_taken", 1);
    pushExp(SEL_PTGT, "alloc_pred_target", 32'h120);
    pushExp(SEL_RED, "idle_redirect", 0);
    pushCounts();
    checkOutput();

    // BNE not taken against a taken prediction: counter drops 10 -> 01, target kept
    applyStimulus(32'h100, 1, 3'b001, 32'h100, 32'h20, 1, 32'h120, 0, 1, 0);
    pushExp(SEL_RED, "bne_redirect", 1);
    pushExp(SEL_RPC, "bne_redirect_pc", 32'h104);
    checkOutput();
    expBr++; expMisp++;
    nextCycle();
    idle(32'h100);
    pushExp(SEL_PT, "bne_pred_taken", 0);
    pushExp(SEL_PTGT, "bne_pred_target", 32'h120);
    pushCounts();
    checkOutput();

    applyStimulus(32'h100, 0, 3'b110, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    pushExp(SEL_SIGN, "bltu_is_sign", 0);
    checkOutput();
    applyStimulus(32'h100, 0, 3'b100, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    pushExp(SEL_SIGN, "blt_is_sign", 1);
    checkOutput();
    applyStimulus(32'h100, 0, 3'b101, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0);
    pushExp(SEL_SIGN, "bge_is_sign", 1);
    checkOutput();

    // BGEU correctly predicted at 0x200 shares index 0 with 0x100 and replaces it
    applyStimulus(32'h200, 1, 3'b111, 32'h200, 32'h40, 1, 32'h240, 0, 0, 0);
    pushExp(SEL_RED, "bgeu_redirect", 0);
    pushExp(SEL_RPC, "bgeu_redirect_pc", 0);
    pushExp(SEL_PT, "bgeu_pre_lookup", 0);
    checkOutput();
    expBr++;
    nextCycle();
    idle(32'h200);
    pushExp(SEL_PT, "bgeu_pred_taken", 1);
    pushExp(SEL_PTGT, "bgeu_pred_target", 32'h240);
    pushCounts();
    checkOutput();
    idle(32'h100);
    pushExp(SEL_PT, "evicted_pred_taken", 0);
    pushExp(SEL_PTGT, "evicted_pred_target", 0);
    checkOutput();

    applyStimulus(32'h100, 1, 3'b010, 32'h100, 32'h20, 1, 32'h999, 0, 1, 1);
    pushExp(SEL_RED, "illegal_redirect", 0);
    checkOutput();
    nextCycle();
    idle(32'h100);
    pushCounts();
    checkOutput();

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h100, 1, 3'b000, 32'h300, 32'h10, 0, 32'h0, 1, 1, 0);
      pushExp(SEL_RED, "stall_redirect", 0);
      pushExp(SEL_FL, "stall_flush", 0);
      checkOutput();
      nextCycle();
    end
    pushCounts();
    checkOutput();
    applyStimulus(32'h100, 1, 3'b000, 32'h300, 32'h10, 0, 32'h0, 0, 1, 0);
    pushExp(SEL_RED, "unstall_redirect", 1);
    pushExp(SEL_RPC, "unstall_redirect_pc", 32'h310);
    checkOutput();
    expBr++; expMisp++;
    nextCycle();
    idle(32'h100);
    pushCounts();
    checkOutput();
    nextCycle();
    pushCounts();
    checkOutput();

    // Index 3: lookup in the same cycle as an update sees the pre-edge entry
    applyStimulus(32'h00C, 1, 3'b000, 32'h00C, 32'h40, 0, 32'h0, 0, 1, 0);
    pushExp(SEL_PT, "idx3_old_taken", 0);
    pushExp(SEL_PTGT, "idx3_old_target", 0);
    pushExp(SEL_RPC, "idx3_redirect_pc", 32'h4C);
    checkOutput();
    expBr++; expMisp++;
    nextCycle();
    applyStimulus(32'h00C, 1, 3'b001, 32'h00C, 32'h80, 1, 32'h4C, 0, 0, 0);
    pushExp(SEL_PT, "idx3_prev_taken", 1);
    pushExp(SEL_PTGT, "idx3_prev_target", 32'h4C);
    pushExp(SEL_RED, "wrong_target_redirect", 1);
    pushExp(SEL_RPC, "wrong_target_pc", 32'h8C);
    checkOutput();
    expBr++; expMisp++;
    nextCycle();
    idle(32'h00C);
    pushExp(SEL_PT, "idx3_new_taken", 1);
    pushExp(SEL_PTGT, "idx3_new_target", 32'h8C);
    pushCounts();
    checkOutput();

    applyStimulus(32'h010, 1, 3'b000, 32'h010, 32'h40, 0, 32'h0, 0, 0, 0);
    pushExp(SEL_RED, "nt_miss_redirect", 0);
    pushExp(SEL_RPC, "nt_miss_redirect_pc", 0);
    checkOutput();
    expBr++;
    nextCycle();
    idle(32'h010);
    pushExp(SEL_PT, "nt_miss_no_alloc", 0);
    pushExp(SEL_PTGT, "nt_miss_no_target", 0);
    pushCounts();
    checkOutput();

    applyStimulus(32'h00C, 1, 3'b000, 32'h020, 32'h8, 0, 32'h0, 0, 1, 0);
    pushExp(SEL_RED, "pre_reset_redirect", 1);
    pushExp(SEL_PT, "pre_reset_pred_taken", 1);
    checkOutput();
    #2;
    rstN = 1'b0;
    #1;
    pushExp(SEL_PT, "rst_pred_taken", 0);
    pushExp(SEL_PTGT, "rst_pred_target", 0);
    pushExp(SEL_RED, "rst_redirect", 0);
    pushExp(SEL_FL, "rst_flush", 0);
    pushExp(SEL_RPC, "rst_redirect_pc", 0);
    expBr = 0; expMisp = 0;
    pushCounts();
    checkOutput();
    nextCycle();
    idle(32'h00C);
    rstN = 1'b1;
    #1;
    pushExp(SEL_PT, "post_rst_pred_taken", 0);
    pushExp(SEL_PTGT, "post_rst_pred_target", 0);
    pushCounts();
    checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
